// File: rtl/keypad_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : keypad_entry_ctrl
// Description : Key-entry controller that sits after the keypad scanner.
//               Each detected key press (rows / debounced_col / enable) is
//               decoded to a hex value and accepted exactly once. Accepted
//               keys shift through a two-digit history (left = older,
//               right = newest). The two digits are time-multiplexed onto a
//               shared seven-segment decoder. A new entry is only allowed
//               after the key has been seen released for RELEASE_CYCLES
//               consecutive cycles.
//
// Optional    : `define KEY_REPEAT_EN builds an auto-repeat hold counter.
//               While a key stays held, the current key_code is re-entered
//               every REPEAT_CYCLES held cycles. Without the macro, no hold
//               counter is built and each press gives exactly one entry.
//
// Parameters  : RELEASE_CYCLES  consecutive enable-low cycles that confirm a
//                               release (>= 1)
//               MUX_DIV         clk cycles per display phase (>= 2)
//               REPEAT_CYCLES   held cycles between auto-repeat entries
//                               (only used with KEY_REPEAT_EN)
//
// Ports       : clk            system clock
//               reset          asynchronous reset, active low
//               rows     [3:0] scanner row drive, one-hot, 4'b1000 = top row
//               debounced_col [3:0]
//                              scanner column, active low,
//                              4'b0111 = leftmost column
//               enable         scanner key-detected flag
//               key_code [3:0] last accepted key
//               key_strobe     one-cycle pulse per accepted entry
//               digit_left  [3:0]  older digit
//               digit_right [3:0]  newest digit
//               busy           press held or release still pending
//               disp_an  [1:0] digit enables, active low (bit1 = left)
//               disp_digit [3:0] value of the currently enabled digit
//
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry_ctrl #(
    parameter int RELEASE_CYCLES = 4,
    parameter int MUX_DIV        = 8,
    parameter int REPEAT_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    input  logic [3:0] debounced_col,
    input  logic       enable,
    output logic [3:0] key_code,
    output logic       key_strobe,
    output logic [3:0] digit_left,
    output logic [3:0] digit_right,
    output logic       busy,
    output logic [1:0] disp_an,
    output logic [3:0] disp_digit
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_REL_W = $clog2(RELEASE_CYCLES) + 1;
    localparam int c_MUX_W = $clog2(MUX_DIV) + 1;

    localparam logic [c_REL_W-1:0] c_REL_TERM = c_REL_W'(RELEASE_CYCLES - 1);
    localparam logic [c_MUX_W-1:0] c_MUX_TERM = c_MUX_W'(MUX_DIV - 1);

    // Active-low digit enables
    localparam logic [1:0] c_AN_RIGHT = 2'b10;
    localparam logic [1:0] c_AN_LEFT  = 2'b01;

`ifdef KEY_REPEAT_EN
    localparam int c_HOLD_W = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_TERM = c_HOLD_W'(REPEAT_CYCLES - 1);
`else
    // Parameter kept for a uniform interface; no hold counter in this build.
    localparam int c_unused_repeat = REPEAT_CYCLES;
`endif

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_REL_W-1:0]  r_rel_cnt;
    logic [c_REL_W-1:0]  w_rel_cnt_nxt;
`ifdef KEY_REPEAT_EN
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_HOLD_W-1:0] w_hold_cnt_nxt;
`endif

    logic                w_load;      // accept a newly decoded key
    logic                w_reissue;   // re-enter the current key (auto-repeat)

    // Registered outputs / datapath
    logic [3:0]          r_key_code;
    logic                r_key_strobe;
    logic [3:0]          r_digit_left;
    logic [3:0]          r_digit_right;
    logic                r_busy;
    logic [c_MUX_W-1:0]  r_mux_cnt;
    logic [1:0]          r_disp_an;

    // ------------------------------------------------------------------
    // Key decode
    // ------------------------------------------------------------------
    logic [1:0] w_row_idx;
    logic [1:0] w_col_idx;
    logic       w_row_ok;
    logic       w_col_ok;
    logic       w_valid;
    logic [3:0] w_key;

    always_comb begin
        w_row_ok  = 1'b1;
        w_row_idx = 2'd0;
        case (rows)
            4'b1000: w_row_idx = 2'd0;
            4'b0100: w_row_idx = 2'd1;
            4'b0010: w_row_idx = 2'd2;
            4'b0001: w_row_idx = 2'd3;
            default: w_row_ok  = 1'b0;
        endcase
    end

    // Column is active low: exactly one zero selects a column, MSB = left.
    always_comb begin
        w_col_ok  = 1'b1;
        w_col_idx = 2'd0;
        case (debounced_col)
            4'b0111: w_col_idx = 2'd0;
            4'b1011: w_col_idx = 2'd1;
            4'b1101: w_col_idx = 2'd2;
            4'b1110: w_col_idx = 2'd3;
            default: w_col_ok  = 1'b0;
        endcase
    end

    assign w_valid = w_row_ok & w_col_ok;

    // Physical keypad layout (row, column) -> hex value
    always_comb begin
        w_key = 4'h0;
        case ({w_row_idx, w_col_idx})
            4'b00_00: w_key = 4'h1;
            4'b00_01: w_key = 4'h2;
            4'b00_10: w_key = 4'h3;
            4'b00_11: w_key = 4'hA;
            4'b01_00: w_key = 4'h4;
            4'b01_01: w_key = 4'h5;
            4'b01_10: w_key = 4'h6;
            4'b01_11: w_key = 4'hB;
            4'b10_00: w_key = 4'h7;
            4'b10_01: w_key = 4'h8;
            4'b10_10: w_key = 4'h9;
            4'b10_11: w_key = 4'hC;
            4'b11_00: w_key = 4'hE;
            4'b11_01: w_key = 4'h0;
            4'b11_10: w_key = 4'hF;
            4'b11_11: w_key = 4'hD;
            default:  w_key = 4'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Entry FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_rel_cnt  <= '0;
`ifdef KEY_REPEAT_EN
            r_hold_cnt <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_rel_cnt  <= w_rel_cnt_nxt;
`ifdef KEY_REPEAT_EN
            r_hold_cnt <= w_hold_cnt_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Entry FSM: next state and entry controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_rel_cnt_nxt  = r_rel_cnt;
        w_load         = 1'b0;
        w_reissue      = 1'b0;
`ifdef KEY_REPEAT_EN
        w_hold_cnt_nxt = r_hold_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                w_rel_cnt_nxt  = '0;
`ifdef KEY_REPEAT_EN
                w_hold_cnt_nxt = '0;
`endif
                // Invalid row/column combinations are simply ignored.
                if (enable && w_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_PRESSED;
                end
            end

            ST_PRESSED: begin
                if (enable) begin
                    // Any detection, even a different key, restarts the
                    // release qualification; no new entry is taken here.
                    w_rel_cnt_nxt = '0;
`ifdef KEY_REPEAT_EN
                    if (r_hold_cnt == c_HOLD_TERM) begin
                        w_reissue      = 1'b1;
                        w_hold_cnt_nxt = '0;
                    end else begin
                        w_hold_cnt_nxt = r_hold_cnt + c_HOLD_W'(1);
                    end
`endif
                end else begin
`ifdef KEY_REPEAT_EN
                    w_hold_cnt_nxt = '0;
`endif
                    if (r_rel_cnt == c_REL_TERM) begin
                        w_state_nxt   = ST_IDLE;
                        w_rel_cnt_nxt = '0;
                    end else begin
                        w_rel_cnt_nxt = r_rel_cnt + c_REL_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_rel_cnt_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Key history, strobe and busy
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_key_code    <= 4'h0;
            r_key_strobe  <= 1'b0;
            r_digit_left  <= 4'h0;
            r_digit_right <= 4'h0;
            r_busy        <= 1'b0;
        end else begin
            r_key_strobe <= w_load | w_reissue;
            r_busy       <= (w_state_nxt == ST_PRESSED);
            if (w_load) begin
                r_key_code    <= w_key;
                r_digit_left  <= r_digit_right;
                r_digit_right <= w_key;
            end else if (w_reissue) begin
                r_digit_left  <= r_digit_right;
                r_digit_right <= r_key_code;
            end
        end
    end

    // ------------------------------------------------------------------
    // Display multiplexer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mux_cnt <= '0;
            r_disp_an <= c_AN_RIGHT;
        end else begin
            if (r_mux_cnt == c_MUX_TERM) begin
                r_mux_cnt <= '0;
                r_disp_an <= (r_disp_an == c_AN_RIGHT) ? c_AN_LEFT : c_AN_RIGHT;
            end else begin
                r_mux_cnt <= r_mux_cnt + c_MUX_W'(1);
            end
        end
    end

    // Combinational from the digit registers so a new digit shows up in
    // the same cycle it is registered.
    assign disp_digit  = (r_disp_an == c_AN_RIGHT) ? r_digit_right : r_digit_left;

    assign key_code    = r_key_code;
    assign key_strobe  = r_key_strobe;
    assign digit_left  = r_digit_left;
    assign digit_right = r_digit_right;
    assign busy        = r_busy;
    assign disp_an     = r_disp_an;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_entry_ctrl
// Description : Self-checking bench for keypad_entry_ctrl. A directed vector
//               table, hand-written reset/mux sequences and randomized
//               stimulus, all checked against a behavioural model of the
//               entry rules (keypad lookup table, press/release run counts,
//               two-entry history, cycle-count based display phase).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_entry_ctrl;

    localparam int RELEASE_CYCLES = 4;
    localparam int MUX_DIV        = 8;
    localparam int REPEAT_CYCLES  = 32;

    logic       clk;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] debounced_col;
    logic       enable;
    logic [3:0] key_code;
    logic       key_strobe;
    logic [3:0] digit_left;
    logic [3:0] digit_right;
    logic       busy;
    logic [1:0] disp_an;
    logic [3:0] disp_digit;

    keypad_entry_ctrl #(
        .RELEASE_CYCLES (RELEASE_CYCLES),
        .MUX_DIV        (MUX_DIV),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rows          (rows),
        .debounced_col (debounced_col),
        .enable        (enable),
        .key_code      (key_code),
        .key_strobe    (key_strobe),
        .digit_left    (digit_left),
        .digit_right   (digit_right),
        .busy          (busy),
        .disp_an       (disp_an),
        .disp_digit    (disp_digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [3:0] keymap [16];   // row-major keypad layout
    bit         m_pressed;
    int         m_lows;
    int         m_hold;
    logic [3:0] m_key;
    logic [3:0] m_left;
    logic [3:0] m_right;
    logic       m_strobe;
    int         m_cyc;

    function automatic logic [1:0] m_an();
        return (((m_cyc / MUX_DIV) % 2) == 0) ? 2'b10 : 2'b01;
    endfunction

    task automatic model_reset();
        m_pressed = 0; m_lows = 0; m_hold = 0;
        m_key = 4'h0; m_left = 4'h0; m_right = 4'h0;
        m_strobe = 1'b0; m_cyc = 0;
    endtask

    task automatic model_accept(input logic [3:0] k);
        m_left   = m_right;
        m_right  = k;
        m_key    = k;
        m_strobe = 1'b1;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic [3:0] c, input logic e);
        int         ri;
        int         ci;
        logic [3:0] nc;
        ri = 0; ci = 0;
        nc = ~c;
        for (int i = 0; i < 4; i++) begin
            if (r[3-i])  ri = i;
            if (nc[3-i]) ci = i;
        end
        m_strobe = 1'b0;
        if (!m_pressed) begin
            if (e && $countones(r) == 1 && $countones(nc) == 1) begin
                model_accept(keymap[ri*4 + ci]);
                m_pressed = 1; m_lows = 0; m_hold = 0;
            end
        end else if (e) begin
            m_lows = 0;
`ifdef KEY_REPEAT_EN
            m_hold++;
            if (m_hold == REPEAT_CYCLES) begin
                model_accept(m_key);
                m_hold = 0;
            end
`endif
        end else begin
            m_hold = 0;
            m_lows++;
            if (m_lows == RELEASE_CYCLES) begin
                m_pressed = 0;
                m_lows    = 0;
            end
        end
        m_cyc++;
    endtask

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " key_code"},    key_code,         m_key);
        chk({tag, " key_strobe"},  {3'b0, key_strobe}, {3'b0, m_strobe});
        chk({tag, " digit_left"},  digit_left,       m_left);
        chk({tag, " digit_right"}, digit_right,      m_right);
        chk({tag, " busy"},        {3'b0, busy},     {3'b0, m_pressed});
        chk({tag, " disp_an"},     {2'b0, disp_an},  {2'b0, m_an()});
        chk({tag, " disp_digit"},  disp_digit,       (m_an() == 2'b10) ? m_right : m_left);
    endtask

    // One clock: inputs already stable, model the edge, sample 1 ns later.
    task automatic step(input logic [3:0] r, input logic [3:0] c, input logic e, input string tag);
        rows = r; debounced_col = c; enable = e;
        @(posedge clk);
        model_edge(r, c, e);
        #1;
        check_model(tag);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0] r;
        logic [3:0] c;
        logic       e;
        int         reps;
        logic       s;
        logic [3:0] k;
        logic [3:0] dl;
        logic [3:0] dr;
        logic       b;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [3:0] r, input logic [3:0] c, input logic e,
                                input int reps, input logic s, input logic [3:0] k,
                                input logic [3:0] dl, input logic [3:0] dr, input logic b);
        vec_t v;
        v.r = r; v.c = c; v.e = e; v.reps = reps; v.s = s;
        v.k = k; v.dl = dl; v.dr = dr; v.b = b;
        return v;
    endfunction

`ifdef KEY_REPEAT_EN
    localparam int HOLD_REPS = 20;   // stays below the auto-repeat interval
`else
    localparam int HOLD_REPS = 50;
`endif

    initial begin
        logic [3:0] pr;
        logic [3:0] pc;
        logic       pe;
        int         run_left;
        int         toggles;
        logic [1:0] prev_an;

        keymap = '{4'h1, 4'h2, 4'h3, 4'hA,
                   4'h4, 4'h5, 4'h6, 4'hB,
                   4'h7, 4'h8, 4'h9, 4'hC,
                   4'hE, 4'h0, 4'hF, 4'hD};

        //            rows     col      en reps   strb key   left  right busy
        tbl.push_back(mk(4'b1000, 4'b0111, 1, 1,         1, 4'h1, 4'h0, 4'h1, 1)); // key 1
        tbl.push_back(mk(4'b1000, 4'b0111, 1, 1,         0, 4'h1, 4'h0, 4'h1, 1));
        tbl.push_back(mk(4'b0000, 4'b1111, 0, 3,         0, 4'h1, 4'h0, 4'h1, 1));
        tbl.push_back(mk(4'b0000, 4'b1111, 0, 1,         0, 4'h1, 4'h0, 4'h1, 0)); // 4th low
        tbl.push_back(mk(4'b0100, 4'b0111, 1, 1,         1, 4'h4, 4'h1, 4'h4, 1)); // key 4
        tbl.push_back(mk(4'b0100, 4'b1011, 1, HOLD_REPS, 0, 4'h4, 4'h1, 4'h4, 1)); // col change held
        tbl.push_back(mk(4'b0000, 4'b1111, 0, 3,         0, 4'h4, 4'h1, 4'h4, 1)); // glitch: 3 low
        tbl.push_back(mk(4'b0100, 4'b1011, 1, 1,         0, 4'h4, 4'h1, 4'h4, 1)); //  1 high
        tbl.push_back(mk(4'b0000, 4'b1111, 0, 3,         0, 4'h4, 4'h1, 4'h4, 1)); //  3 low
        tbl.push_back(mk(4'b0000, 4'b1111, 0, 1,         0, 4'h4, 4'h1, 4'h4, 0)); //  4th low
        tbl.push_back(mk(4'b0001, 4'b1110, 1, 1,         1, 4'hD, 4'h4, 4'hD, 1)); // key D
        tbl.push_back(mk(4'b0001, 4'b1110, 1, 1,         0, 4'hD, 4'h4, 4'hD, 1));
        tbl.push_back(mk(4'b0000, 4'b1111, 0, 3,         0, 4'hD, 4'h4, 4'hD, 1));
        tbl.push_back(mk(4'b0000, 4'b1111, 0, 1,         0, 4'hD, 4'h4, 4'hD, 0));
        tbl.push_back(mk(4'b1100, 4'b0111, 1, 2,         0, 4'hD, 4'h4, 4'hD, 0)); // two rows
        tbl.push_back(mk(4'b1000, 4'b0011, 1, 2,         0, 4'hD, 4'h4, 4'hD, 0)); // two cols
        tbl.push_back(mk(4'b0000, 4'b0111, 1, 1,         0, 4'hD, 4'h4, 4'hD, 0)); // no row
        tbl.push_back(mk(4'b1000, 4'b1111, 1, 1,         0, 4'hD, 4'h4, 4'hD, 0)); // no col
        tbl.push_back(mk(4'b0010, 4'b1101, 1, 1,         1, 4'h9, 4'hD, 4'h9, 1)); // key 9
        tbl.push_back(mk(4'b0000, 4'b1111, 0, 3,         0, 4'h9, 4'hD, 4'h9, 1));
        tbl.push_back(mk(4'b0000, 4'b1111, 0, 1,         0, 4'h9, 4'hD, 4'h9, 0));

        // --------------------------------------------------------------
        // Power-on reset
        // --------------------------------------------------------------
        rows = 4'b0000; debounced_col = 4'b1111; enable = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        #1;
        check_model("por");

        // Run the mux counter and hold a key, then reset mid-press
        for (int i = 0; i < 5; i++) step(4'b0000, 4'b1111, 1'b0, "pre_idle");
        step(4'b0010, 4'b1110, 1'b1, "pre_press");   // key C
        step(4'b0010, 4'b1110, 1'b1, "pre_hold");
        #2;
        reset = 1'b0;                                  // asynchronous assertion
        model_reset();
        #1;
        check_model("async_rst");
        chk("async_rst disp_an", {2'b0, disp_an}, 4'b0010);
        #19;
        reset = 1'b1;
        rows = 4'b0000; debounced_col = 4'b1111; enable = 1'b0;
        #1;
        check_model("rst_release");

        // --------------------------------------------------------------
        // Directed table
        // --------------------------------------------------------------
        foreach (tbl[t]) begin
            for (int n = 0; n < tbl[t].reps; n++) begin
                step(tbl[t].r, tbl[t].c, tbl[t].e, $sformatf("tbl%0d", t));
                chk($sformatf("tbl%0d strobe", t), {3'b0, key_strobe}, {3'b0, tbl[t].s});
                chk($sformatf("tbl%0d key", t),    key_code,          tbl[t].k);
                chk($sformatf("tbl%0d left", t),   digit_left,        tbl[t].dl);
                chk($sformatf("tbl%0d right", t),  digit_right,       tbl[t].dr);
                chk($sformatf("tbl%0d busy", t),   {3'b0, busy},      {3'b0, tbl[t].b});
            end
        end

        // --------------------------------------------------------------
        // Display mux with left = 1, right = D
        // --------------------------------------------------------------
        step(4'b1000, 4'b0111, 1'b1, "mux_p1");
        for (int i = 0; i < RELEASE_CYCLES; i++) step(4'b0000, 4'b1111, 1'b0, "mux_r1");
        step(4'b0001, 4'b1110, 1'b1, "mux_pD");
        for (int i = 0; i < RELEASE_CYCLES; i++) step(4'b0000, 4'b1111, 1'b0, "mux_rD");
        chk("mux left",  digit_left,  4'h1);
        chk("mux right", digit_right, 4'hD);
        toggles = 0;
        prev_an = disp_an;
        for (int i = 0; i < 2 * MUX_DIV; i++) begin
            step(4'b0000, 4'b1111, 1'b0, "mux_obs");
            if (disp_an != prev_an) toggles++;
            prev_an = disp_an;
            chk("mux digit", disp_digit, (disp_an == 2'b10) ? 4'hD : 4'h1);
        end
        chk("mux toggles", 4'(toggles), 4'd2);

        // --------------------------------------------------------------
        // Randomized stimulus: runs of enable high/low with mostly
        // valid keys and occasional mid-run key changes
        // --------------------------------------------------------------
        pe = 1'b0; pr = 4'b0000; pc = 4'b1111; run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                pe       = ~pe;
                run_left = (pe && $urandom_range(0, 19) == 0) ? $urandom_range(30, 70)
                                                              : $urandom_range(1, 8);
                pr = ($urandom_range(0, 9) < 8) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom);
                pc = ($urandom_range(0, 9) < 8) ? ~4'(1 << $urandom_range(0, 3)) : 4'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
                pc = ~4'(1 << $urandom_range(0, 3));
            end
            run_left--;
            step(pr, pc, pe, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
